// File: rtl/mem_model_pkg.sv
// Shared types and constants for the cpu memory responder model.
package mem_model_pkg;

  localparam int WORD_BITS = 32;
  localparam int STRB_BITS = 4;
  localparam int CNT_BITS  = 4;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Wait counter never wraps, it holds at its maximum.
  function automatic logic [CNT_BITS-1:0] cnt_inc(input logic [CNT_BITS-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/mem_model_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module mem_model_ram
  import mem_model_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic [AW-1:0]        addr,
  input  logic [STRB_BITS-1:0] we,
  input  logic [WORD_BITS-1:0] wdata,
  output logic [WORD_BITS-1:0] rdata
);

  logic [WORD_BITS-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM macros; its contents after reset are whatever was last written.
  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_BITS; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_resp_model.sv
// Memory responder for cpu verification wrappers: valid/ready port backed by a byte-strobed RAM,
// with bounded wait states and range/protocol violation flags.
module mem_resp_model
  import mem_model_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int MAX_WAIT  = 4,
  parameter int LAT_MODE  = 0,
  parameter int FIXED_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 memory_valid,
  input  logic                 memory_instr,
  input  logic [31:0]          memory_addr,
  input  logic [WORD_BITS-1:0] memory_wdata,
  input  logic [STRB_BITS-1:0] memory_wstrb,
  output logic [WORD_BITS-1:0] memory_rdata,
  output logic                 memory_ready,
  input  logic                 stall,
  output logic                 range_err,
  output logic                 proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_BITS-1:0] FIXED_CNT = CNT_BITS'(FIXED_LAT);
  localparam logic [CNT_BITS-1:0] MAX_CNT   = CNT_BITS'(MAX_WAIT);

  state_t               state, state_nxt;
  logic [CNT_BITS-1:0]  cnt, cnt_nxt;
  logic [31:0]          cap_addr;
  logic [WORD_BITS-1:0] cap_wdata;
  logic [STRB_BITS-1:0] cap_wstrb;
  logic                 cap_instr;
  logic                 cap_in_range;
  logic                 cap_is_read;
  logic                 viol;
  logic [AW-1:0]        ram_addr;
  logic [STRB_BITS-1:0] ram_we;
  logic [WORD_BITS-1:0] ram_q;

  function automatic logic wait_done(input logic [CNT_BITS-1:0] c, input logic s);
    if (LAT_MODE == 1) return c == FIXED_CNT;
    else               return !s || (c == MAX_CNT);
  endfunction

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (memory_valid) begin
          cnt_nxt   = '0;
          state_nxt = wait_done('0, stall) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt_inc(cnt);
        if (wait_done(cnt_nxt, stall)) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
      cap_instr <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      proto_err <= proto_err | viol;
      if (state == IDLE && memory_valid) begin
        cap_addr  <= memory_addr;
        cap_wdata <= memory_wdata;
        cap_wstrb <= memory_wstrb;
        cap_instr <= memory_instr;
      end
    end
  end

  // Full 30-bit index compare: out-of-range addresses never alias onto RAM words.
  assign cap_in_range = cap_addr[31:2] < 30'(DEPTH);
  // An instruction fetch carrying byte enables is served as a read.
  assign cap_is_read  = (cap_wstrb == '0) || cap_instr;

  always_comb begin
    viol = 1'b0;
    if ((state == WAIT || state == RESP) && !memory_valid) viol = 1'b1;
    if (state == WAIT && (memory_addr != cap_addr || memory_wdata != cap_wdata ||
                          memory_wstrb != cap_wstrb)) viol = 1'b1;
    if (state == IDLE && memory_valid && memory_instr && memory_wstrb != '0) viol = 1'b1;
  end

  // The read port follows the live address in IDLE so data is ready even when WAIT is skipped.
  assign ram_addr = (state == IDLE) ? memory_addr[AW+1:2] : cap_addr[AW+1:2];
  assign ram_we   = (state == RESP && cap_in_range && !cap_instr) ? cap_wstrb : '0;

  mem_model_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (cap_wdata),
    .rdata (ram_q)
  );

  assign memory_ready = (state == RESP);
  assign range_err    = (state == RESP) && !cap_in_range;
  assign memory_rdata = (state == RESP && cap_is_read && cap_in_range) ? ram_q : '0;

endmodule

// File: tb/tb_mem_resp_model.sv
// Bench for mem_resp_model: a fixed-latency and a stall-driven instance checked against a word-array model.
module tb_mem_resp_model;

  localparam int DEPTH = 1024;
  localparam int FL    = 2;
  localparam int MW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, valid, instr, stall, ready, range_err, proto_err;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0][3:0]  wstrb;

  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  logic [31:0] mem_m [2][DEPTH];
  logic [1:0]  exp_proto;

  mem_resp_model #(.DEPTH(DEPTH), .MAX_WAIT(MW), .LAT_MODE(1), .FIXED_LAT(FL)) dut_fixed (
    .clk(clk), .rst(rst[0]), .memory_valid(valid[0]), .memory_instr(instr[0]),
    .memory_addr(addr[0]), .memory_wdata(wdata[0]), .memory_wstrb(wstrb[0]),
    .memory_rdata(rdata[0]), .memory_ready(ready[0]), .stall(stall[0]),
    .range_err(range_err[0]), .proto_err(proto_err[0])
  );

  mem_resp_model #(.DEPTH(DEPTH), .MAX_WAIT(MW), .LAT_MODE(0), .FIXED_LAT(FL)) dut_stall (
    .clk(clk), .rst(rst[1]), .memory_valid(valid[1]), .memory_instr(instr[1]),
    .memory_addr(addr[1]), .memory_wdata(wdata[1]), .memory_wstrb(wstrb[1]),
    .memory_rdata(rdata[1]), .memory_ready(ready[1]), .stall(stall[1]),
    .range_err(range_err[1]), .proto_err(proto_err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Outside a response the data and range outputs must be quiet.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (!rst[i] && !ready[i]) begin
          check($sformatf("quiet_rdata%0d", i), rdata[i], 32'h0);
          check($sformatf("quiet_range%0d", i), 32'(range_err[i]), 32'h0);
        end
      end
    end
  end

  // mode: 0 normal, 1 change addr in WAIT, 2 drop valid in WAIT, 3 reset in WAIT.
  // sb[k] is the stall level seen at the k-th edge after the request is presented.
  task automatic xact(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic ins, input int mode, input logic [MW:0] sb,
                      output logic [31:0] rd, output int lat);
    int          w;
    logic [29:0] idx;
    logic        in_range, is_wr;
    logic [31:0] exp_rd;
    idx      = a[31:2];
    in_range = idx < 30'(DEPTH);
    is_wr    = (s != 4'h0) && !ins;
    if (i == 0) w = FL;
    else begin
      w = MW;
      for (int k = MW; k >= 0; k--) if (!sb[k]) w = k;
    end
    exp_rd = (!is_wr && in_range) ? mem_m[i][idx[9:0]] : 32'h0;
    if (ins && s != 4'h0)         exp_proto[i] = 1'b1;
    if (mode == 1 || mode == 2)   exp_proto[i] = 1'b1;
    rd  = '0;
    lat = -1;
    valid[i] = 1'b1; addr[i] = a; wdata[i] = d; wstrb[i] = s; instr[i] = ins; stall[i] = sb[0];
    for (int j = 0; j <= w; j++) begin
      @(posedge clk); #1;
      stall[i] = (j < MW) ? sb[j+1] : 1'b0;
      if (j == 0) begin
        case (mode)
          1: addr[i]  = a ^ 32'h4;
          2: valid[i] = 1'b0;
          3: rst[i]   = 1'b1;
          default: ;
        endcase
      end
      @(negedge clk);
      if (mode == 3) begin
        check("rst_ready", 32'(ready[i]), 32'h0);
        break;
      end
      check($sformatf("ready%0d_c%0d", i, j), 32'(ready[i]), 32'(j == w));
      if (ready[i] && lat < 0) lat = j + 1;
      if (j == w) begin
        rd = rdata[i];
        check($sformatf("rdata%0d", i), rdata[i], exp_rd);
        check($sformatf("range%0d", i), 32'(range_err[i]), 32'(!in_range));
        check($sformatf("proto%0d", i), 32'(proto_err[i]), 32'(exp_proto[i]));
      end
    end
    @(posedge clk); #1;
    valid[i] = 1'b0;
    stall[i] = 1'b0;
    if (mode == 3) begin
      rst[i]       = 1'b0;
      exp_proto[i] = 1'b0;
    end else if (is_wr && in_range) begin
      for (int b = 0; b < 4; b++) if (s[b]) mem_m[i][idx[9:0]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [29:0] idx;
    case ($urandom_range(0, 9))
      0:       idx = 30'd1024 + 30'($urandom_range(0, 7));
      1:       idx = 30'h3FFF_FFFF;
      2:       idx = 30'h2000_0000 | 30'($urandom_range(0, 15));
      default: idx = 30'($urandom_range(0, 15));
    endcase
    return {idx, 2'($urandom_range(0, 3))};
  endfunction

  logic [31:0] rd;
  int          lat;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 2'b11; valid = '0; instr = '0; stall = '0; addr = '0; wdata = '0; wstrb = '0;
    exp_proto = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_ready", 32'(ready[i]), 32'h0);
      check("reset_rdata", rdata[i], 32'h0);
      check("reset_range", 32'(range_err[i]), 32'h0);
      check("reset_proto", 32'(proto_err[i]), 32'h0);
    end
    @(posedge clk); #1;
    rst = 2'b00;
    mon_en = 1'b1;

    // Give every low word a known value in both instances.
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < 2; i++)
        xact(i, 32'(k * 4), $urandom, 4'hF, 1'b0, 0, 5'($urandom), rd, lat);

    // Fixed latency of 2 waits: ready three edges after the request.
    xact(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 0, 5'h1F, rd, lat);
    check("t1_wr_lat", 32'(lat), 32'd3);
    xact(0, 32'h10, 32'h0, 4'h0, 1'b0, 0, 5'h00, rd, lat);
    check("t1_rd_lat", 32'(lat), 32'd3);
    check("t1_rd_data", rd, 32'hDEAD_BEEF);

    xact(0, 32'h10, 32'h0000_AA00, 4'h2, 1'b0, 0, 5'h00, rd, lat);
    xact(0, 32'h10, 32'h0, 4'h0, 1'b0, 0, 5'h00, rd, lat);
    check("t2_byte_data", rd, 32'hDEAD_AAEF);

    // Stall-driven: permanent stall is bounded by MAX_WAIT, no stall answers next edge.
    xact(1, 32'h8, 32'h0, 4'h0, 1'b0, 0, 5'h1F, rd, lat);
    check("t3_stall_lat", 32'(lat), 32'd5);
    xact(1, 32'h8, 32'h0, 4'h0, 1'b0, 0, 5'h00, rd, lat);
    check("t3_nostall_lat", 32'(lat), 32'd1);
    xact(1, 32'h8, 32'h0, 4'h0, 1'b0, 0, 5'b11100, rd, lat);
    check("t3_partial_lat", 32'(lat), 32'd1);
    xact(1, 32'h8, 32'h0, 4'h0, 1'b0, 0, 5'b11011, rd, lat);
    check("t3_drop2_lat", 32'(lat), 32'd3);

    // Out-of-range index: flagged, zero data, and the write must not alias onto word 0.
    xact(1, 32'h0, 32'h1234_5678, 4'hF, 1'b0, 0, 5'h00, rd, lat);
    xact(1, 32'h1000, 32'h0, 4'h0, 1'b0, 0, 5'h00, rd, lat);
    check("t4_range_rdata", rd, 32'h0);
    xact(1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b0, 0, 5'h00, rd, lat);
    xact(1, 32'h0, 32'h0, 4'h0, 1'b0, 0, 5'h00, rd, lat);
    check("t4_no_alias", rd, 32'h1234_5678);

    // Address changed in WAIT: sticky flag, response from the captured address.
    xact(0, 32'h10, 32'h0, 4'h0, 1'b0, 1, 5'h00, rd, lat);
    check("t5_captured_data", rd, 32'hDEAD_AAEF);
    xact(0, 32'h0, 32'h0, 4'h0, 1'b0, 0, 5'h00, rd, lat);
    @(negedge clk);
    check("t5_proto_sticky", 32'(proto_err[0]), 32'h1);

    // Reset during WAIT drops the write and clears the flag.
    xact(0, 32'h10, 32'hCAFE_F00D, 4'hF, 1'b0, 3, 5'h00, rd, lat);
    @(negedge clk);
    check("t6_proto_cleared", 32'(proto_err[0]), 32'h0);
    xact(0, 32'h10, 32'h0, 4'h0, 1'b0, 0, 5'h00, rd, lat);
    check("t6_write_dropped", rd, 32'hDEAD_AAEF);
    check("t6_lat_after_rst", 32'(lat), 32'd3);

    // Randomized traffic on both instances, with occasional idle gaps.
    for (int n = 0; n < 300; n++) begin
      int          i;
      logic [3:0]  s;
      logic        ins;
      logic [MW:0] sb;
      i   = $urandom_range(0, 1);
      s   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      ins = (s == 4'h0) ? 1'($urandom) : 1'b0;
      sb  = ($urandom_range(0, 3) == 0) ? 5'h1F : 5'($urandom);
      xact(i, rand_addr(), $urandom, s, ins, 0, sb, rd, lat);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("gap_ready", 32'(ready[i]), 32'h0);
      end
    end

    // Instruction fetch with byte enables: flagged and served as a read.
    xact(1, 32'h8, 32'h5555_5555, 4'hF, 1'b1, 0, 5'($urandom), rd, lat);
    xact(1, 32'h8, 32'h0, 4'h0, 1'b0, 0, 5'h00, rd, lat);
    // Valid dropped during WAIT: still completes, flag set.
    xact(0, 32'h4, 32'h0, 4'h0, 1'b0, 2, 5'h00, rd, lat);
    check("drop_valid_lat", 32'(lat), 32'd3);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
